// File: rtl/uart_rx.sv
// uart_rx - 8N1 asynchronous serial receiver with 16x oversampling.
//
// Frame: one start bit (low), 8 data bits LSB first, one stop bit (high),
// line idles high. Each bit is resolved by a 3-sample majority vote taken
// at oversample ticks 7, 8 and 9 of the bit period.
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   rx_pin     - serial line, asynchronous to clk, idle high
//   data       - received byte, stable while valid=1
//   valid      - holding register contains an unconsumed byte
//   ready      - consumer takes the byte when valid & ready at a clk edge
//   frame_err  - one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    - one-cycle pulse: new byte dropped, holding register full
//   parity_err - one-cycle pulse: even-parity mismatch (0 when disabled)
//   busy       - receiver is not in IDLE
//
// Build option: define UART_RX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.

module uart_rx #(
    parameter int BAUD_DIV   = 13,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_pin,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t     state, state_nx;
    logic       rx_m, rx_s;
    logic [7:0] div_cnt;
    logic [3:0] s_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic       smp7, smp8;
    logic       tick, mid, wrap, maj;
    logic       byte_done, stop_bad;

    // Two-flop synchronizer, preset high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_pin;
            rx_s <= rx_m;
        end
    end

    assign tick = (state != S_IDLE) && (div_cnt == 8'(BAUD_DIV - 1));
    assign mid  = tick && (s_cnt == 4'd9);
    assign wrap = tick && (s_cnt == 4'(OVERSAMPLE - 1));
    // Third vote is the live sample at tick 9.
    assign maj  = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nx = S_START;
            end
            S_START: begin
                if (mid && maj)  state_nx = S_IDLE;
                else if (wrap)   state_nx = S_DATA;
            end
            S_DATA: begin
                if (wrap && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (wrap) state_nx = S_STOP;
            end
            S_STOP: begin
                // Leave at mid-stop so a slightly fast transmitter's next
                // start bit is not missed.
                if (mid) begin
                    state_nx  = S_IDLE;
                    byte_done = maj;
                    stop_bad  = !maj;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Oversample timing and bit assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            s_cnt   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            smp7    <= 1'b1;
            smp8    <= 1'b1;
        end else begin
            if (state == S_IDLE) begin
                div_cnt <= '0;
                s_cnt   <= '0;
            end else if (tick) begin
                div_cnt <= '0;
                s_cnt   <= (s_cnt == 4'(OVERSAMPLE - 1)) ? 4'd0 : s_cnt + 4'd1;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (tick && s_cnt == 4'd7) smp7 <= rx_s;
            if (tick && s_cnt == 4'd8) smp8 <= rx_s;

            if (state == S_START)
                bit_idx <= '0;
            else if (state == S_DATA && wrap)
                bit_idx <= bit_idx + 3'd1;

            if (state == S_DATA && mid)
                shreg <= {maj, shreg[7:1]};
        end
    end

    // Holding register and status pulses; all visible the cycle after
    // the stop-bit decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            overrun   <= byte_done && valid && !ready;
            if (byte_done) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (state == S_PARITY && mid) par_bit <= maj;
            parity_err <= byte_done && ((^shreg) ^ par_bit);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8-bit asynchronous serial receiver: 8 data bits, LSB first, 1 stop bit, idle-high line, 16x oversampling.
- Companion to the team's uart_tx. Sits between a dedicated input pin (ui_in bit) and on-chip consumers.
- Delivers each received byte through a single-entry valid/ready holding register.
- Reports framing errors and overruns.

Parameters:
- BAUD_DIV, 13, clk cycles per oversample tick (24 MHz / (13*16) ≈ 115200 baud); legal range 1..255.
- OVERSAMPLE, 16, ticks per bit; fixed at 16, not to be overridden.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- rx_pin  input  1  serial line, asynchronous to clk, idle high
- data  output  8  received byte; stable while valid=1
- valid  output  1  byte available in holding register
- ready  input  1  consumer accepts byte when valid&ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: byte dropped because holding register was full
- parity_err  output  1  one-cycle pulse: parity mismatch (tied 0 without the optional feature)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: asynchronous on rst_n low. All outputs 0 (data=8'h00). State=IDLE. Synchronizer flops preset to 1. Counters cleared.
- Reset mid-frame: the frame is abandoned and no output pulses occur. After release the receiver waits for a fresh falling edge in IDLE.
- Synchronizer: rx_pin passes through 2 flops; rx_s is the second flop. All logic uses rx_s only.
- Tick generator: div_cnt counts 0..BAUD_DIV-1, tick=1 when div_cnt==BAUD_DIV-1. div_cnt is held at 0 in IDLE, so the first tick of a frame falls BAUD_DIV cycles after START entry.
- Sample counter: s_cnt 0..15, advances on each tick and wraps 15→0, which also advances the bit.
- Sampling: rx_s captured at s_cnt 7, 8, 9. Bit value = majority of the 3 samples.
- IDLE → START: when rx_s==0. div_cnt and s_cnt cleared.
- START: bit decided on the tick at s_cnt==9.
  - Majority 1: false start; return to IDLE with no pulse.
  - Majority 0: continue; at s_cnt wrap go to DATA with bit index 0.
- DATA: each bit is decided at s_cnt==9 and shifted in LSB first. After bit index 7 wraps, go to STOP (or PARITY when enabled).
- STOP: decided at s_cnt==9, then immediately return to IDLE (no wait for bit end, tolerates fast transmitters).
  - Stop=1: byte complete.
  - Stop=0: frame_err pulses for 1 cycle; byte discarded; valid/data unchanged.
- Byte-complete cycle (call it C); holding-register updates appear the cycle after C:
  - valid=0: data←byte, valid←1.
  - valid=1 and ready=1 in C: old byte consumed, new byte loaded, valid stays 1.
  - valid=1 and ready=0 in C: overrun pulses; new byte dropped; old data/valid held.
- Handshake: valid&ready with no completion → valid←0 next cycle. data is held (not cleared).
- Latency: from the stop-bit mid-sample tick to valid=1 is 1 cycle. From rx_pin falling edge to IDLE exit is 2–3 cycles (synchronizer).
- Line held low (break): reported as frame_err. The receiver then sits in IDLE, restarts START as soon as it sees rx_s==0, and false-starts repeatedly only if the line rises; otherwise it produces one frame_err per 10 bit times.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, expecting even parity (XOR of 8 data bits and parity bit = 0), decided at s_cnt==9.
  - On mismatch, parity_err pulses 1 cycle in the byte-complete cycle (requires valid stop). The byte is still delivered.
  - On a frame error, only frame_err pulses.
- Undefined: no PARITY state; parity_err tied 0; frame is 10 bits.

Test Plan:
- BAUD_DIV=2 (32 clk/bit), ready=1, send 8'hA5 with valid stop → single-cycle valid with data=8'hA5; frame_err=overrun=parity_err=0 throughout.
- Idle line, drive rx_pin low for 8 clk then high → busy pulses briefly, returns to IDLE; no valid or frame_err.
- Send 8'h3C with stop bit=0 → frame_err=1 for exactly 1 cycle; valid stays 0; next frame 8'h5A received correctly.
- ready=0, send 8'h11 then 8'h22 back-to-back → valid=1 with data=8'h11 held; overrun pulses once at 8'h22 completion. Then assert ready 1 cycle → valid=0, data=8'h11.
- Assert rst_n=0 for 3 clk during bit 4 of 8'hFF, release, send 8'h80 → only 8'h80 delivered; no error pulses.
- With UART_RX_PARITY_EN: send 8'h07 with parity=1 → data=8'h07, parity_err=0. Send 8'h07 with parity=0 → data=8'h07 delivered, parity_err pulses 1 cycle.
